// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus bundle for apb_cmd_master.
// The master modport is the initiator's view; the slave modport is everything around it.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: one command in, one SETUP/ACCESS transfer out,
// one response back; ACCESS is abandoned after TIMEOUT waited cycles (0 = never).
//
//  state  | meaning
//  IDLE   | waiting for a command; cmd_ready high
//  SETUP  | psel high, penable low, one cycle
//  ACCESS | psel and penable high until pready or timeout
//  RESP   | response presented until rsp_ready
module apb_cmd_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_cmd_master_if.master    bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               expire;

    // pready has priority: expiry only counts on a cycle the slave is still stalling
    assign expire = (TIMEOUT != 0) && (state_q == ACCESS) && !bus.pready && (cnt_q == CNT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.pready || expire) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it
    always_comb begin
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = (state_d == SETUP) || (state_d == ACCESS);
        penable_d     = (state_d == ACCESS);
        rsp_valid_d   = (state_d == RESP);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                end
            end
            ACCESS: begin
                if (bus.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    cnt_d         = '0;
                end else if (expire) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master: plays an APB slave with chosen wait states
// and predicts every transfer and response from the command and slave behaviour.
module tb_apb_cmd_master;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TO = 16;

    logic pclk;
    logic presetn;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   t_acc;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry and exit: at a falling edge with the DUT idle.
    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] rd, input bit serr, input int rdly);
        bit            to;
        int            exp_acc;
        int            acc;
        bit            stable;
        bit            held;
        logic [DW-1:0] e_rd;
        bit            e_err;

        to      = (TO != 0) && (waits >= TO);
        exp_acc = to ? TO : waits + 1;
        e_rd    = (wr || to) ? '0 : rd;
        e_err   = to ? 1'b1 : serr;

        chk("idle_cmd_ready", bus.cmd_ready, 1);
        t_acc         = cyc;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.pready    = 1'(($urandom));
        bus.pslverr   = 1'(($urandom));
        @(negedge pclk);

        chk("setup_psel", bus.psel, 1);
        chk("setup_penable", bus.penable, 0);
        chk("setup_ctrl", {bus.pwrite, bus.paddr, bus.pwdata}, {wr, addr, wd});
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'(($urandom));
        bus.cmd_write = 1'(($urandom));
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
        bus.pready    = 1'(($urandom));
        @(negedge pclk);

        acc    = 0;
        stable = 1'b1;
        while (bus.psel && bus.penable && acc < 64) begin
            acc++;
            if ({bus.pwrite, bus.paddr, bus.pwdata} !== {wr, addr, wd} || bus.cmd_ready !== 1'b0)
                stable = 1'b0;
            if (acc > waits) begin
                bus.pready  = 1'b1;
                bus.prdata  = rd;
                bus.pslverr = serr;
            end else begin
                bus.pready  = 1'b0;
                bus.prdata  = DW'($urandom);
                bus.pslverr = 1'(($urandom));
            end
            @(negedge pclk);
        end
        chk("access_cycles", acc, exp_acc);
        chk("access_stable", stable, 1);
        bus.pready  = 1'(($urandom));
        bus.prdata  = DW'($urandom);
        bus.pslverr = 1'(($urandom));

        chk("resp_valid", bus.rsp_valid, 1);
        chk("resp_bus_idle", {bus.psel, bus.penable}, 0);
        chk("resp_fields", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {e_rd, e_err, to});
        chk("resp_busy", {bus.busy, bus.cmd_ready}, 2'b10);

        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        held = 1'b1;
        repeat (rdly) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0 ||
                {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e_rd, e_err, to})
                held = 1'b0;
        end
        if (rdly > 0) chk("resp_held", held, 1);
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk("resp_done", {bus.rsp_valid, bus.cmd_ready, bus.busy}, 3'b010);
        bus.rsp_ready = 1'(($urandom));
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        bit quiet;

        n_vec = 0;
        n_err = 0;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        repeat (3) @(negedge pclk);
        chk("reset_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
        chk("reset_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.busy}, 0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);

        do_cmd(1'b1, 5'h08, 8'h15, 0, 8'h00, 1'b0, 0);
        do_cmd(1'b0, 5'h04, 8'h00, 3, 8'hA5, 1'b0, 0);
        do_cmd(1'b0, 5'h1F, 8'h00, 0, 8'h3C, 1'b1, 0);
        do_cmd(1'b0, 5'h02, 8'h00, 100, 8'h11, 1'b0, 0);
        do_cmd(1'b0, 5'h03, 8'h00, TO - 1, 8'h77, 1'b0, 0);
        do_cmd(1'b1, 5'h0A, 8'h5A, 1, 8'h00, 1'b1, 5);

        do_cmd(1'b1, 5'h01, 8'h01, 0, 8'h00, 1'b0, 0);
        t0 = t_acc;
        do_cmd(1'b0, 5'h02, 8'h00, 0, 8'h22, 1'b0, 0);
        t1 = t_acc;
        do_cmd(1'b1, 5'h03, 8'h33, 0, 8'h00, 1'b0, 0);
        t2 = t_acc;
        chk("b2b_spacing_1", t1 - t0, 4);
        chk("b2b_spacing_2", t2 - t1, 4);

        // abort a waited read with reset
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 5'h06;
        bus.pready    = 1'b0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge pclk);
        chk("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
        #2 presetn = 1'b0;
        #1;
        chk("async_reset", {bus.psel, bus.penable, bus.rsp_valid, bus.busy}, 0);
        @(negedge pclk);
        presetn = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        chk("post_reset_ready", bus.cmd_ready, 1);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) quiet = 1'b0;
        end
        chk("no_stale_rsp", quiet, 1);

        for (int i = 0; i < 150; i++) begin
            int w;
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 4));
            do_cmd(1'(($urandom)), AW'($urandom), DW'($urandom), w, DW'($urandom),
                   1'(($urandom)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator that converts a simple valid/ready command stream into single APB3 transfers (SETUP then ACCESS) toward the UART register slave.
- Returns read data and error status on a valid/ready response channel.
- Supports pready wait states, captures pslverr, and aborts hung transfers with a programmable timeout.
- Sits between the system/test sequencer and the UART register block; one transfer outstanding at a time.

Parameters:
- ADDR_W, 5, width of cmd_addr/paddr.
- DATA_W, 8, width of wdata/rdata.
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error, valid with pready.

Behaviour:
- Reset (async, presetn low):
  - state = IDLE; wait counter = 0.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and busy are all 0.
  - cmd_ready = 1 after reset releases.
  - Reset mid-transfer drops psel/penable immediately; no response is generated for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready = (state == IDLE) and busy = (state != IDLE).
- IDLE:
  - On cmd_valid & cmd_ready, register cmd_write/addr/wdata onto pwrite/paddr/pwdata and go to SETUP.
  - Otherwise, APB address and data outputs hold their last values.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; next state is ACCESS.
- ACCESS: psel = 1, penable = 1.
  - pready = 1 → go to RESP.
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr; rsp_timeout = 0.
    - Clear the wait counter.
  - pready = 0 → increment the wait counter.
  - If TIMEOUT != 0 and the counter equals TIMEOUT - 1 while pready = 0 → go to RESP.
    - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - Exactly TIMEOUT ACCESS cycles elapse before the abort.
- pready = 1 in the same cycle the timeout fires: pready wins; normal completion.
- paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle.
- psel and penable drop to 0 on the cycle after completion or abort.
- RESP:
  - rsp_valid = 1; rsp_rdata, rsp_err and rsp_timeout are held stable.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_ready low stalls the block indefinitely; no new command is accepted.
- Minimum turnaround with pready and rsp_ready tied high: 4 cycles per command (IDLE accept, SETUP, ACCESS, RESP). cmd_ready is high every 4th cycle.
- Wait counter width is clog2(TIMEOUT+1); minimum 1 bit.
- cmd_* inputs are ignored when cmd_ready = 0.
- pslverr is ignored when pready = 0.
- prdata is sampled only on the completing ACCESS cycle.

Test Plan:
- Write, no wait states: cmd_write=1, addr=0x08, wdata=0x15, pready=1 → SETUP then ACCESS with paddr=0x08, pwdata=0x15, pwrite=1. rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x04, pready low 3 cycles then high with prdata=0xA5 → penable high 4 cycles, paddr stable throughout. rsp_rdata=0xA5, rsp_err=0.
- Slave error: read addr=0x1F, pready=1 with pslverr=1 → rsp_err=1, rsp_timeout=0, next command accepted after rsp_ready.
- Timeout, TIMEOUT=16, pready stuck low → exactly 16 ACCESS cycles, then psel=0. rsp_err=1, rsp_timeout=1, rsp_rdata=0. pready rising on the 16th cycle instead yields normal completion.
- Back-pressure and back-to-back: rsp_ready low 5 cycles → rsp_valid and fields held, cmd_ready=0, cmd_valid ignored. With rsp_ready high, 3 queued commands issue at a 4-cycle spacing.
- Reset mid-ACCESS: assert presetn low during a waited read → psel, penable and rsp_valid are 0 asynchronously. After release, cmd_ready=1 and no stale response appears.
